// File: rtl/pairhmm_fp_pkg.sv
// Shared constants and state encodings for the Pair-HMM floating-point datapath.
package pairhmm_fp_pkg;

    localparam logic [63:0] DBL_ZERO = 64'h0000000000000000;
    localparam logic [63:0] DBL_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] DBL_QNAN = 64'hFFF8000000000000;

    typedef enum logic [2:0] {
        IDLE,
        NEXT,
        ISSUE,
        WAIT,
        DONE
    } acc_state_t;

endpackage

// File: rtl/double_adder.sv
// Multi-cycle IEEE-754 double adder, round-to-nearest-even, with denormal and NaN/Inf handling.
// Samples operands in S_UNPACK, then holds done/output_z until rst is pulsed.
module double_adder
    import pairhmm_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic [63:0] input_b,
    input  logic        input_valid,
    output logic [63:0] output_z,
    output logic        done
);

    typedef enum logic [2:0] {
        S_UNPACK,
        S_SPECIAL,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_PACK,
        S_DONE
    } add_state_t;

    add_state_t  state;
    logic [63:0] a_q, b_q;
    logic        big_s, sml_s, z_s;
    logic [12:0] big_e, sml_e, z_e;
    logic [56:0] big_m, sml_m, z_m;

    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [6:0]  lz;
    logic [12:0] norm_sh;
    logic        rnd_up;
    logic [53:0] rnd_m;

    function automatic logic [12:0] exp_of(input logic [63:0] x);
        return (x[62:52] == 11'd0) ? 13'd1 : {2'b00, x[62:52]};
    endfunction

    // Layout: carry | hidden | 52 fraction bits | guard | round | sticky.
    function automatic logic [56:0] man_of(input logic [63:0] x);
        return {1'b0, |x[62:52], x[51:0], 3'b000};
    endfunction

    function automatic logic [56:0] shr_sticky(input logic [56:0] m, input logic [12:0] d);
        logic [56:0] r;
        logic [56:0] mask;
        if (d > 13'd56) begin
            return {56'd0, |m};
        end
        r    = m >> d;
        mask = (57'd1 << d) - 57'd1;
        r[0] = r[0] | (|(m & mask));
        return r;
    endfunction

    function automatic logic [6:0] lzc56(input logic [55:0] v);
        logic [6:0] n;
        n = 7'd56;
        for (int i = 0; i < 56; i++) begin
            if (v[i]) n = 7'(55 - i);
        end
        return n;
    endfunction

    assign a_nan  = (&a_q[62:52]) && (|a_q[51:0]);
    assign b_nan  = (&b_q[62:52]) && (|b_q[51:0]);
    assign a_inf  = (&a_q[62:52]) && !(|a_q[51:0]);
    assign b_inf  = (&b_q[62:52]) && !(|b_q[51:0]);
    assign a_zero = (a_q[62:0] == 63'd0);
    assign b_zero = (b_q[62:0] == 63'd0);
    assign a_big  = (a_q[62:0] >= b_q[62:0]);

    // Left shift never takes the exponent below 1, so tiny results fall out as denormals.
    always_comb begin
        lz      = lzc56(z_m[55:0]);
        norm_sh = ({6'd0, lz} < (z_e - 13'd1)) ? {6'd0, lz} : (z_e - 13'd1);
        rnd_up  = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);
        rnd_m   = {1'b0, z_m[55:3]} + {53'd0, rnd_up};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_UNPACK;
            done  <= 1'b0;
        end else begin
            unique case (state)
                S_UNPACK: begin
                    if (input_valid) begin
                        a_q   <= input_a;
                        b_q   <= input_b;
                        state <= S_SPECIAL;
                    end
                end
                S_SPECIAL: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    if (a_nan || b_nan || (a_inf && b_inf && (a_q[63] != b_q[63]))) begin
                        output_z <= DBL_QNAN;
                    end else if (a_inf) begin
                        output_z <= a_q;
                    end else if (b_inf) begin
                        output_z <= b_q;
                    end else if (a_zero && b_zero) begin
                        output_z <= {a_q[63] & b_q[63], 63'd0};
                    end else if (a_zero) begin
                        output_z <= b_q;
                    end else if (b_zero) begin
                        output_z <= a_q;
                    end else begin
                        state <= S_ALIGN;
                        done  <= 1'b0;
                        big_s <= a_big ? a_q[63] : b_q[63];
                        big_e <= exp_of(a_big ? a_q : b_q);
                        big_m <= man_of(a_big ? a_q : b_q);
                        sml_s <= a_big ? b_q[63] : a_q[63];
                        sml_e <= exp_of(a_big ? b_q : a_q);
                        sml_m <= man_of(a_big ? b_q : a_q);
                    end
                end
                S_ALIGN: begin
                    sml_m <= shr_sticky(sml_m, big_e - sml_e);
                    state <= S_ADD;
                end
                S_ADD: begin
                    z_m   <= (big_s == sml_s) ? (big_m + sml_m) : (big_m - sml_m);
                    z_e   <= big_e;
                    z_s   <= big_s;
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (z_m[56]) begin
                        z_m <= {1'b0, z_m[56:2], z_m[1] | z_m[0]};
                        z_e <= z_e + 13'd1;
                    end else begin
                        z_m <= z_m << norm_sh;
                        z_e <= z_e - norm_sh;
                    end
                    // Exact cancellation yields +0 under round-to-nearest.
                    if (z_m == 57'd0) z_s <= 1'b0;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    z_m   <= {1'b0, (rnd_m[53] ? rnd_m[53:1] : rnd_m[52:0]), 3'b000};
                    z_e   <= z_e + {12'd0, rnd_m[53]};
                    state <= S_PACK;
                end
                S_PACK: begin
                    if (z_e >= 13'd2047) begin
                        output_z <= {z_s, 11'h7FF, 52'd0};
                    end else begin
                        output_z <= {z_s, (z_m[55] ? z_e[10:0] : 11'd0), z_m[54:3]};
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: state <= S_UNPACK;
            endcase
        end
    end

endmodule

// File: rtl/double_accumulator.sv
// Streaming double-precision packet summer: folds each packet serially through one
// double_adder and reports the sum and element count on a valid/ready output.
module double_accumulator
    import pairhmm_fp_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    acc_state_t        state;
    logic [63:0]       acc;
    logic [63:0]       opnd;
    logic [CNT_W-1:0]  cnt;
    logic              last_q;
    logic              err;
    logic              drop;
    logic [WCNT_W-1:0] wcnt;

    logic              accept;
    logic              add_rst;
    logic              add_valid;
    logic              add_done;
    logic [63:0]       add_z;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : (c + 1'b1);
    endfunction

    assign in_ready  = (state == IDLE) || (state == NEXT);
    assign accept    = in_valid && in_ready;
    assign add_rst   = reset || ((state == NEXT) && in_valid);
    assign add_valid = (state == ISSUE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_err   = err;

    double_adder u_add (
        .clk         (clk),
        .rst         (add_rst),
        .input_a     (acc),
        .input_b     (opnd),
        .input_valid (add_valid),
        .output_z    (add_z),
        .done        (add_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= DBL_ZERO;
            opnd   <= DBL_ZERO;
            cnt    <= '0;
            last_q <= 1'b0;
            err    <= 1'b0;
            drop   <= 1'b0;
            wcnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // Leftovers of a timed-out packet are swallowed up to their last flag.
                        if (drop) begin
                            if (in_last) drop <= 1'b0;
                        end else begin
                            acc   <= in_data;
                            cnt   <= CNT_W'(1);
                            state <= in_last ? DONE : NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (accept) begin
                        opnd   <= in_data;
                        last_q <= in_last;
                        cnt    <= sat_inc(cnt);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        acc   <= add_z;
                        state <= last_q ? DONE : NEXT;
                    end else if (wcnt == WCNT_W'(TIMEOUT)) begin
                        acc   <= DBL_QNAN;
                        err   <= 1'b1;
                        drop  <= !last_q;
                        state <= DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_double_accumulator.sv
// Directed bench for double_accumulator: vector table, stall/reset/timeout sequences
// and a back-to-back packet stream against a real-valued reference sum.
module tb_double_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic        sel;

    logic        in_ready1, out_valid1, out_err1;
    logic [63:0] out_sum1;
    logic [15:0] out_count1;
    logic        in_ready2, out_valid2, out_err2;
    logic [63:0] out_sum2;
    logic [1:0]  out_count2;

    logic        cur_ready, cur_valid, cur_err;
    logic [63:0] cur_sum;
    logic [15:0] cur_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    int          cnt_q[$];

    typedef struct packed {
        logic [3:0][63:0] d;
        logic [2:0]       n;
        logic [63:0]      esum;
        logic [15:0]      ecnt;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    double_accumulator #(.CNT_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready1), .out_sum(out_sum1), .out_count(out_count1), .out_err(out_err1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    double_accumulator #(.CNT_W(2), .TIMEOUT(4)) dut_tmo (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready2), .out_sum(out_sum2), .out_count(out_count2), .out_err(out_err2),
        .out_valid(out_valid2), .out_ready(out_ready)
    );

    assign cur_ready = sel ? in_ready2  : in_ready1;
    assign cur_valid = sel ? out_valid2 : out_valid1;
    assign cur_err   = sel ? out_err2   : out_err1;
    assign cur_sum   = sel ? out_sum2   : out_sum1;
    assign cur_count = sel ? {14'd0, out_count2} : out_count1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!cur_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for element %h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!cur_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cur_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid got 0, expected 1 within 400 cycles", name);
        end
    endtask

    task automatic get_result(input string name, input logic [63:0] esum,
                              input logic [15:0] ecnt, input logic eerr);
        wait_valid(name);
        chk({name, "_sum"}, cur_sum, esum);
        chk({name, "_cnt"}, 64'(cur_count), 64'(ecnt));
        chk({name, "_err"}, 64'(cur_err), 64'(eerr));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mkv(input int n, input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3,
                                 input logic [63:0] esum, input logic [15:0] ecnt);
        vec_t v;
        v.n    = 3'(n);
        v.d[0] = d0;
        v.d[1] = d1;
        v.d[2] = d2;
        v.d[3] = d3;
        v.esum = esum;
        v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 64'd0;
        out_ready = 1'b0;
        sel       = 1'b0;

        // 2.0 | 1+2+3 | 1-1 | inf-inf | 0.5+0.25+0.125-1 | ties-to-even | sticky round-up | denormals
        vt[0] = mkv(1, 64'h4000000000000000, 64'h0, 64'h0, 64'h0, 64'h4000000000000000, 16'd1);
        vt[1] = mkv(3, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 64'h0,
                    64'h4018000000000000, 16'd3);
        vt[2] = mkv(2, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0, 64'h0,
                    64'h0000000000000000, 16'd2);
        vt[3] = mkv(2, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h0, 64'h0,
                    64'hFFF8000000000000, 16'd2);
        vt[4] = mkv(4, 64'h3FE0000000000000, 64'h3FD0000000000000, 64'h3FC0000000000000,
                    64'hBFF0000000000000, 64'hBFC0000000000000, 16'd4);
        vt[5] = mkv(3, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3CA0000000000000, 64'h0,
                    64'h3FF0000000000000, 16'd3);
        vt[6] = mkv(2, 64'h3FF0000000000000, 64'h3CA0000000000001, 64'h0, 64'h0,
                    64'h3FF0000000000001, 16'd2);
        vt[7] = mkv(2, 64'h0000000000000001, 64'h0000000000000001, 64'h0, 64'h0,
                    64'h0000000000000002, 16'd2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 64'(cur_ready), 64'd1);
        chk("rst_out_valid", 64'(cur_valid), 64'd0);
        chk("rst_out_err", 64'(cur_err), 64'd0);
        chk("rst_out_sum", cur_sum, 64'd0);
        chk("rst_out_count", 64'(cur_count), 64'd0);

        for (int i = 0; i < 8; i++) begin
            for (int e = 0; e < int'(vt[i].n); e++) begin
                push(vt[i].d[e], e == int'(vt[i].n) - 1);
            end
            if (vt[i].n == 3'd1) begin
                @(negedge clk);
                chk("single_latency", 64'(cur_valid), 64'd1);
            end
            get_result($sformatf("vec%0d", i), vt[i].esum, vt[i].ecnt, 1'b0);
        end

        // Output held while downstream stalls.
        push(64'h3FF0000000000000, 1'b0);
        push(64'h3FF0000000000000, 1'b1);
        wait_valid("stall");
        for (int c = 0; c < 10; c++) begin
            chk("stall_sum", cur_sum, 64'h4000000000000000);
            chk("stall_ctl", {46'd0, cur_valid, cur_ready, cur_count}, {46'd0, 1'b1, 1'b0, 16'd2});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", 64'(cur_valid), 64'd0);
        chk("post_hs_ready", 64'(cur_ready), 64'd1);

        // Reset while the adder is busy.
        push(64'h3FF0000000000000, 1'b0);
        push(64'h4000000000000000, 1'b1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 64'(cur_valid), 64'd0);
        chk("midrst_ready", 64'(cur_ready), 64'd1);
        chk("midrst_sum", cur_sum, 64'd0);
        reset = 1'b0;
        push(64'h3FE0000000000000, 1'b1);
        get_result("after_rst", 64'h3FE0000000000000, 16'd1, 1'b0);

        // Short-timeout instance: abort, drop trailing element, recover, saturate.
        sel = 1'b1;
        pulse_reset();
        push(64'h3FF0000000000000, 1'b0);
        push(64'h4000000000000000, 1'b0);
        get_result("timeout", 64'hFFF8000000000000, 16'd2, 1'b1);
        push(64'h4008000000000000, 1'b1);
        @(negedge clk);
        chk("drop_valid", 64'(cur_valid), 64'd0);
        chk("drop_ready", 64'(cur_ready), 64'd1);
        push(64'h3FE0000000000000, 1'b1);
        get_result("after_drop", 64'h3FE0000000000000, 16'd1, 1'b0);
        push(64'h3FF0000000000000, 1'b0);
        for (int k = 0; k < 4; k++) push(64'h0, k == 3);
        get_result("saturate", 64'h3FF0000000000000, 16'd3, 1'b0);

        // Back-to-back packets against a real-valued reference.
        sel = 1'b0;
        pulse_reset();
        fork
            begin : producer
                for (int p = 0; p < 6; p++) begin
                    int          len;
                    int          v;
                    real         s;
                    logic [63:0] el [5];
                    len = int'($urandom_range(1, 5));
                    s   = 0.0;
                    for (int e = 0; e < len; e++) begin
                        v     = int'($urandom_range(0, 16)) - 8;
                        el[e] = $realtobits(real'(v));
                        s     = s + real'(v);
                    end
                    exp_q.push_back($realtobits(s));
                    cnt_q.push_back(len);
                    for (int e = 0; e < len; e++) push(el[e], e == len - 1);
                end
            end
            begin : consumer
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                out_ready = 1'b1;
                while (got < 6 && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (cur_valid) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL stream_extra: got result %h, expected none", cur_sum);
                        end else begin
                            chk("stream_sum", cur_sum, exp_q.pop_front());
                            chk("stream_cnt", 64'(cur_count), 64'(cnt_q.pop_front()));
                        end
                        got++;
                    end
                end
                if (got < 6) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_timeout: got %0d results, expected 6", got);
                end
                out_ready = 1'b0;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
